pmodenc_cmd_sequencer: RTL and testbench
========================================

// Module: pmodenc_cmd_sequencer
// PURPOSE
//  Sequences and arbitrates all control traffic to the PmodENC rotary encoder core. Two requesters
//  (software via register handshake, hardware clear button) are arbitrated and turned into
//  single-cycle clearCount/loadConfig pulses and config buses. The block then captures a coherent
//  count snapshot and keeps a saturating count of encoder events.
//  Sits between the AXI register slice and the encoder core.
// PARAMETERS
//  CNTR_WIDTH          16  width of encoder count / snapshot
//  EVT_WIDTH           16  width of saturating event counter
//  SETTLE_CYCLES       2   wait cycles after a pulse before capture (>=1)
//  DFLT_INCRDECRVALUE  1   reset value of enc_incrDecrValue
//  DFLT_NONEG          0   reset value of enc_noNeg
// PORTS
//  clk               in   1           system clock
//  reset             in   1           asynchronous reset, active-low
//  sw_req            in   1           SW command request, level, held until sw_done
//  sw_cmd            in   2           00=CLEAR 01=LOAD_CFG 10=SNAPSHOT 11=reserved
//  sw_noNeg          in   1           noNeg value for LOAD_CFG
//  sw_incrDecr       in   4           incr/decr value for LOAD_CFG
//  sw_busy           out  1           sequencer not accepting SW commands
//  sw_done           out  1           1-cycle pulse, SW command complete
//  sw_err            out  1           valid with sw_done; 1 = reserved cmd
//  hw_clr_req        in   1           debounced clear button, level
//  enc_clearCount    out  1           1-cycle clear pulse to encoder
//  enc_loadConfig    out  1           1-cycle config load pulse to encoder
//  enc_noNeg         out  1           config to encoder
//  enc_incrDecrValue out  4           config to encoder
//  enc_encEvent      in   1           event pulse from encoder
//  enc_count         in   CNTR_WIDTH  signed count from encoder
//  snap_count        out  CNTR_WIDTH  last captured count
//  snap_valid        out  1           set on first capture, cleared only by reset
//  evt_count         out  EVT_WIDTH   saturating event count
// BEHAVIOUR
//  - Reset (async, low): FSM=IDLE; all pulses, sw_done, sw_err, snap_count, snap_valid, evt_count = 0;
//    hw_pend = 0; enc_incrDecrValue = DFLT_INCRDECRVALUE; enc_noNeg = DFLT_NONEG.
//    The hw edge-detect history register resets to 1, so a button held through reset is not a request.
//    Reset mid-sequence aborts immediately with no done pulse.
//  - hw_clr_req rising edge sets hw_pend; cleared when IDLE grants it. Edges while pending merge.
//  - sw_busy = (state != IDLE) | hw_pend. All outputs are registered.
//  - FSM: IDLE -> ISSUE -> SETTLE -> CAPTURE -> DONE -> IDLE.
//    IDLE: hw_pend has priority and starts a CLEAR with no sw_done.
//      Otherwise sw_req latches sw_cmd; LOAD_CFG latches config onto enc_* in that same cycle.
//      Reserved cmd -> DONE with err=1 (no pulse, no capture).
//    ISSUE (1 cycle): CLEAR -> enc_clearCount=1; LOAD_CFG -> enc_loadConfig=1; SNAPSHOT -> none.
//    SETTLE: exactly SETTLE_CYCLES cycles.
//    CAPTURE: if enc_encEvent=1, stay (count not yet updated).
//      Else snap_count <= enc_count, snap_valid <= 1, go to DONE.
//    DONE (1 cycle): sw_done=1 (SW-origin only), sw_err per cmd.
//  - Latency (S=SETTLE_CYCLES, no events): accept at N, pulse at N+1, capture at N+2+S, sw_done at N+3+S.
//    Reserved cmd: sw_done at N+1.
//  - evt_count: +1 per enc_encEvent and saturates at all-ones.
//    Reset to 0 in the cycle enc_clearCount is driven; clear wins over a coincident event.
//  - enc config outputs hold their value between LOAD_CFG commands.
// TESTING
//  1 reset, S=2, sw_cmd=SNAPSHOT, enc_count=16'h0005 -> sw_done 5 cycles after accept,
//    snap_count=5, snap_valid=1, no enc pulses.
//  2 LOAD_CFG with noNeg=1, incr=4'hF -> enc_incrDecrValue=F at accept; one enc_loadConfig pulse
//    at N+1; sw_done at N+5, sw_err=0.
//  3 hw_clr_req rise same cycle as sw_req=CLEAR -> hw CLEAR first with no sw_done; SW CLEAR accepted
//    at the cycle after IDLE return; two clearCount pulses total.
//  4 enc_encEvent high for 3 cycles entering CAPTURE -> capture delayed 3 cycles, snap_count is the
//    post-event count.
//  5 EVT_WIDTH=4, 20 events -> evt_count=4'hF; event coincident with clear pulse -> evt_count=0.
//  6 sw_cmd=11 -> sw_done+sw_err at N+1, no pulses; reset asserted in SETTLE -> all outputs
//    default at once, no sw_done.

Source files
------------

// File: rtl/pmodenc_cmd_sequencer.sv
// pmodenc_cmd_sequencer
// Arbitrates software register commands and the hardware clear button into
// single-cycle clearCount/loadConfig pulses for the PmodENC encoder core.
// After each command it waits for the core to settle, then captures a
// coherent count snapshot. It also keeps a saturating count of encoder events.
module pmodenc_cmd_sequencer #(
  parameter int         CNTR_WIDTH         = 16,
  parameter int         EVT_WIDTH          = 16,
  parameter int         SETTLE_CYCLES      = 2,
  parameter logic [3:0] DFLT_INCRDECRVALUE = 4'd1,
  parameter logic       DFLT_NONEG         = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sw_req,
  input  logic [1:0]            sw_cmd,
  input  logic                  sw_noNeg,
  input  logic [3:0]            sw_incrDecr,
  output logic                  sw_busy,
  output logic                  sw_done,
  output logic                  sw_err,
  input  logic                  hw_clr_req,
  output logic                  enc_clearCount,
  output logic                  enc_loadConfig,
  output logic                  enc_noNeg,
  output logic [3:0]            enc_incrDecrValue,
  input  logic                  enc_encEvent,
  input  logic [CNTR_WIDTH-1:0] enc_count,
  output logic [CNTR_WIDTH-1:0] snap_count,
  output logic                  snap_valid,
  output logic [EVT_WIDTH-1:0]  evt_count
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] CMD_CLEAR    = 2'b00;
  localparam logic [1:0] CMD_LOAD_CFG = 2'b01;
  localparam logic [1:0] CMD_SNAPSHOT = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  is_sw_q, is_sw_d;
  logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic                  hw_prev_q, hw_prev_d;
  logic                  hw_pend_q, hw_pend_d;
  logic                  sw_busy_q, sw_busy_d;
  logic                  sw_done_q, sw_done_d;
  logic                  sw_err_q, sw_err_d;
  logic                  clr_q, clr_d;
  logic                  load_q, load_d;
  logic                  no_neg_q, no_neg_d;
  logic [3:0]            incr_q, incr_d;
  logic [CNTR_WIDTH-1:0] snap_count_q, snap_count_d;
  logic                  snap_valid_q, snap_valid_d;
  logic [EVT_WIDTH-1:0]  evt_count_q, evt_count_d;

  logic hw_rise;
  logic hw_want;
  logic hw_grant;

  // Next-state logic: button edge detect, arbitration, sequencing and event counting
  always_comb begin
    state_d      = state_q;
    is_sw_d      = is_sw_q;
    settle_cnt_d = settle_cnt_q;
    hw_prev_d    = hw_clr_req;
    no_neg_d     = no_neg_q;
    incr_d       = incr_q;
    snap_count_d = snap_count_q;
    snap_valid_d = snap_valid_q;
    sw_done_d    = 1'b0;
    sw_err_d     = 1'b0;
    clr_d        = 1'b0;
    load_d       = 1'b0;
    hw_grant     = 1'b0;

    // A rising edge seen this very cycle competes in arbitration immediately,
    // so a button press coincident with a SW request still wins.
    hw_rise = hw_clr_req & ~hw_prev_q;
    hw_want = hw_pend_q | hw_rise;

    case (state_q)
      IDLE: begin
        if (hw_want) begin
          hw_grant = 1'b1;
          is_sw_d  = 1'b0;
          clr_d    = 1'b1;
          state_d  = ISSUE;
        end else if (sw_req) begin
          is_sw_d = 1'b1;
          case (sw_cmd)
            CMD_CLEAR: begin
              clr_d   = 1'b1;
              state_d = ISSUE;
            end
            CMD_LOAD_CFG: begin
              no_neg_d = sw_noNeg;
              incr_d   = sw_incrDecr;
              load_d   = 1'b1;
              state_d  = ISSUE;
            end
            CMD_SNAPSHOT: begin
              state_d = ISSUE;
            end
            default: begin
              sw_done_d = 1'b1;
              sw_err_d  = 1'b1;
              state_d   = DONE;
            end
          endcase
        end
      end
      ISSUE: begin
        settle_cnt_d = SETTLE_W'(SETTLE_CYCLES - 1);
        state_d      = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
        end
      end
      CAPTURE: begin
        // An event in flight means enc_count is about to change; wait it out.
        if (!enc_encEvent) begin
          snap_count_d = enc_count;
          snap_valid_d = 1'b1;
          sw_done_d    = is_sw_q;
          state_d      = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    hw_pend_d = hw_want & ~hw_grant;
    sw_busy_d = (state_d != IDLE) | hw_pend_d;

    // The clear pulse to the core also zeroes the event tally and beats any event in that cycle.
    if (clr_q) begin
      evt_count_d = '0;
    end else if (enc_encEvent && (evt_count_q != '1)) begin
      evt_count_d = evt_count_q + EVT_WIDTH'(1);
    end else begin
      evt_count_d = evt_count_q;
    end
  end

  // State and output registers; reset aborts any sequence without a done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      is_sw_q      <= 1'b0;
      settle_cnt_q <= '0;
      hw_prev_q    <= 1'b1;
      hw_pend_q    <= 1'b0;
      sw_busy_q    <= 1'b0;
      sw_done_q    <= 1'b0;
      sw_err_q     <= 1'b0;
      clr_q        <= 1'b0;
      load_q       <= 1'b0;
      no_neg_q     <= DFLT_NONEG;
      incr_q       <= DFLT_INCRDECRVALUE;
      snap_count_q <= '0;
      snap_valid_q <= 1'b0;
      evt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      is_sw_q      <= is_sw_d;
      settle_cnt_q <= settle_cnt_d;
      hw_prev_q    <= hw_prev_d;
      hw_pend_q    <= hw_pend_d;
      sw_busy_q    <= sw_busy_d;
      sw_done_q    <= sw_done_d;
      sw_err_q     <= sw_err_d;
      clr_q        <= clr_d;
      load_q       <= load_d;
      no_neg_q     <= no_neg_d;
      incr_q       <= incr_d;
      snap_count_q <= snap_count_d;
      snap_valid_q <= snap_valid_d;
      evt_count_q  <= evt_count_d;
    end
  end

  assign sw_busy           = sw_busy_q;
  assign sw_done           = sw_done_q;
  assign sw_err            = sw_err_q;
  assign enc_clearCount    = clr_q;
  assign enc_loadConfig    = load_q;
  assign enc_noNeg         = no_neg_q;
  assign enc_incrDecrValue = incr_q;
  assign snap_count        = snap_count_q;
  assign snap_valid        = snap_valid_q;
  assign evt_count         = evt_count_q;

endmodule

// File: tb/tb_pmodenc_cmd_sequencer.sv
// Testbench for pmodenc_cmd_sequencer.
// Each stimulus pushes its expected pulses and completions into a queue.
// A negedge monitor pops one entry for every clear, load or done pulse it sees,
// so it catches wrong timing as well as pulses that should not have appeared.
module tb_pmodenc_cmd_sequencer;

  localparam int CW = 16;
  localparam int EW = 4;
  localparam int S  = 2;

  localparam int K_CLR  = 0;
  localparam int K_LOAD = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int          kind;
    int          at;
    logic        err;
    logic [15:0] snap;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          sw_req;
  logic [1:0]    sw_cmd;
  logic          sw_noNeg;
  logic [3:0]    sw_incrDecr;
  logic          sw_busy;
  logic          sw_done;
  logic          sw_err;
  logic          hw_clr_req;
  logic          enc_clearCount;
  logic          enc_loadConfig;
  logic          enc_noNeg;
  logic [3:0]    enc_incrDecrValue;
  logic          enc_encEvent;
  logic [CW-1:0] enc_count;
  logic [CW-1:0] snap_count;
  logic          snap_valid;
  logic [EW-1:0] evt_count;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   monEn = 1'b0;
  exp_t expq[$];
  int   evtModel;
  int   n;

  pmodenc_cmd_sequencer #(
    .CNTR_WIDTH(CW),
    .EVT_WIDTH(EW),
    .SETTLE_CYCLES(S),
    .DFLT_INCRDECRVALUE(4'd1),
    .DFLT_NONEG(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_req(sw_req),
    .sw_cmd(sw_cmd),
    .sw_noNeg(sw_noNeg),
    .sw_incrDecr(sw_incrDecr),
    .sw_busy(sw_busy),
    .sw_done(sw_done),
    .sw_err(sw_err),
    .hw_clr_req(hw_clr_req),
    .enc_clearCount(enc_clearCount),
    .enc_loadConfig(enc_loadConfig),
    .enc_noNeg(enc_noNeg),
    .enc_incrDecrValue(enc_incrDecrValue),
    .enc_encEvent(enc_encEvent),
    .enc_count(enc_count),
    .snap_count(snap_count),
    .snap_valid(snap_valid),
    .evt_count(evt_count)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle index: the interval after the n-th rising edge is cycle n
  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Match one observed output pulse against the oldest outstanding expectation
  task automatic popCompare(input int kind);
    exp_t e;
    if (expq.size() == 0) begin
      checkOutput("spurious_output", 32'(expq.size()), 32'd1);
    end else begin
      e = expq.pop_front();
      checkOutput("out_kind", 32'(kind), 32'(e.kind));
      checkOutput("out_cycle", 32'(cyc), 32'(e.at));
      if (kind == K_DONE) begin
        checkOutput("done_err", 32'(sw_err), 32'(e.err));
        checkOutput("done_snap", 32'(snap_count), 32'(e.snap));
        checkOutput("done_snap_valid", 32'(snap_valid), 32'd1);
      end
    end
  endtask

  // Monitor watches all pulse outputs mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (monEn) begin
      if (enc_clearCount) popCompare(K_CLR);
      if (enc_loadConfig) popCompare(K_LOAD);
      if (sw_done) popCompare(K_DONE);
    end
  end

  // Raise a SW request (optionally with a simultaneous button press) and queue what must follow
  task automatic applyStimulus(input logic [1:0] cmd, input logic nn, input logic [3:0] inc,
                               input bit withHw, input int capDelay, input logic [15:0] snap,
                               output int acceptAt);
    @(posedge clk);
    #1;
    acceptAt = cyc;
    if (withHw) begin
      hw_clr_req = 1'b1;
      expq.push_back('{kind: K_CLR, at: cyc + 1, err: 1'b0, snap: 16'h0});
      acceptAt = cyc + S + 4;
    end
    sw_cmd      = cmd;
    sw_noNeg    = nn;
    sw_incrDecr = inc;
    sw_req      = 1'b1;
    if (cmd == 2'b11) begin
      expq.push_back('{kind: K_DONE, at: acceptAt + 1, err: 1'b1, snap: snap});
    end else begin
      if (cmd == 2'b00) expq.push_back('{kind: K_CLR, at: acceptAt + 1, err: 1'b0, snap: 16'h0});
      if (cmd == 2'b01) expq.push_back('{kind: K_LOAD, at: acceptAt + 1, err: 1'b0, snap: 16'h0});
      expq.push_back('{kind: K_DONE, at: acceptAt + 3 + S + capDelay, err: 1'b0, snap: snap});
    end
  endtask

  // Hold the request until sw_done shows up, with a bounded wait
  task automatic waitDone(input int acceptAt);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (cyc == acceptAt + 1) checkOutput("busy_after_accept", 32'(sw_busy), 32'd1);
      if (sw_done) seen = 1'b1;
    end
    sw_req = 1'b0;
    if (!seen) checkOutput("done_timeout", 32'(sw_done), 32'd1);
  endtask

  // Global watchdog so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios
  initial begin
    reset        = 1'b0;
    sw_req       = 1'b0;
    sw_cmd       = 2'b00;
    sw_noNeg     = 1'b0;
    sw_incrDecr  = 4'h0;
    hw_clr_req   = 1'b0;
    enc_encEvent = 1'b0;
    enc_count    = '0;
    evtModel     = 0;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    monEn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(sw_busy), 32'd0);
    checkOutput("rst_done", 32'(sw_done), 32'd0);
    checkOutput("rst_incr", 32'(enc_incrDecrValue), 32'd1);
    checkOutput("rst_noneg", 32'(enc_noNeg), 32'd0);
    checkOutput("rst_snap_valid", 32'(snap_valid), 32'd0);
    checkOutput("rst_snap", 32'(snap_count), 32'd0);
    checkOutput("rst_evt", 32'(evt_count), 32'd0);

    // Snapshot: no encoder pulses, done 5 cycles after accept
    enc_count = 16'h0005;
    applyStimulus(2'b10, 1'b0, 4'h0, 1'b0, 0, 16'h0005, n);
    waitDone(n);
    checkOutput("snap_valid_set", 32'(snap_valid), 32'd1);

    // Config load
    applyStimulus(2'b01, 1'b1, 4'hF, 1'b0, 0, 16'h0005, n);
    waitDone(n);
    checkOutput("cfg_incr", 32'(enc_incrDecrValue), 32'hF);
    checkOutput("cfg_noneg", 32'(enc_noNeg), 32'd1);

    // Button and SW clear in the same cycle: hardware first, then software
    enc_count = 16'h0007;
    applyStimulus(2'b00, 1'b0, 4'h0, 1'b1, 0, 16'h0007, n);
    waitDone(n);
    hw_clr_req = 1'b0;
    checkOutput("cfg_hold_incr", 32'(enc_incrDecrValue), 32'hF);
    checkOutput("cfg_hold_noneg", 32'(enc_noNeg), 32'd1);

    // Events while entering capture delay it until the count has moved on
    enc_count = 16'd100;
    applyStimulus(2'b10, 1'b0, 4'h0, 1'b0, 3, 16'd103, n);
    repeat (S + 2) begin
      @(posedge clk);
      #1;
    end
    enc_encEvent = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    enc_encEvent = 1'b0;
    enc_count    = 16'd103;
    waitDone(n);
    evtModel = 3;
    checkOutput("evt_after_capture", 32'(evt_count), 32'(evtModel));

    // Saturation of the event counter
    @(posedge clk);
    #1;
    enc_encEvent = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    enc_encEvent = 1'b0;
    evtModel = (evtModel + 20 > 15) ? 15 : evtModel + 20;
    @(posedge clk);
    #1;
    checkOutput("evt_saturated", 32'(evt_count), 32'(evtModel));

    // An event coincident with the clear pulse loses to the clear
    enc_count = 16'h0009;
    applyStimulus(2'b00, 1'b0, 4'h0, 1'b0, 0, 16'h0009, n);
    @(posedge clk);
    #1;
    enc_encEvent = 1'b1;
    @(posedge clk);
    #1;
    enc_encEvent = 1'b0;
    evtModel = 0;
    checkOutput("evt_clear_wins", 32'(evt_count), 32'(evtModel));
    waitDone(n);

    // Reserved command: immediate error completion, snapshot unchanged
    enc_count = 16'h00AA;
    applyStimulus(2'b11, 1'b0, 4'h0, 1'b0, 0, 16'h0009, n);
    waitDone(n);

    // Reset in SETTLE aborts at once; a button held through reset is not a request
    enc_count = 16'h1234;
    applyStimulus(2'b10, 1'b0, 4'h0, 1'b0, 0, 16'h1234, n);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset      = 1'b0;
    sw_req     = 1'b0;
    hw_clr_req = 1'b1;
    expq.delete();
    #1;
    checkOutput("abort_busy", 32'(sw_busy), 32'd0);
    checkOutput("abort_snap_valid", 32'(snap_valid), 32'd0);
    checkOutput("abort_snap", 32'(snap_count), 32'd0);
    checkOutput("abort_incr", 32'(enc_incrDecrValue), 32'd1);
    checkOutput("abort_noneg", 32'(enc_noNeg), 32'd0);
    checkOutput("abort_evt", 32'(evt_count), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checkOutput("held_button_busy", 32'(sw_busy), 32'd0);
    hw_clr_req = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checkOutput("queue_drained", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
